// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the multiplexed seven-segment scanner.
//   - Parameter defaults for digit count, slot length and blink period.
//   - Active-low 7-bit glyphs {g,f,e,d,c,b,a} for hex digits 0..F.
//   - SEG_BLANK: the all-off 8-bit segment pattern.
//   - disp_mode_e: meaning of the scanner's mode input.
package seven_seg_pkg;

   localparam int DEF_DIGITS       = 8;
   localparam int DEF_SCAN_DIV     = 50000;
   localparam int DEF_BLINK_FRAMES = 64;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   // Glyph used for a leading zero that is blanked (decimal point kept separately).
   localparam logic [6:0] GLYPH_OFF = 7'h7F;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic {
      MODE_HEX = 1'b0,
      MODE_RAW = 1'b1
   } disp_mode_e;

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational nibble to active-low seven-segment glyph.
//   nib_i   [3:0] hex value 0..F
//   glyph_o [6:0] active-low {g,f,e,d,c,b,a}
module hex7seg_dec
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] glyph_o
);

   always_comb begin
      glyph_o = GLYPH_8;
      case (nib_i)
         4'h0: glyph_o = GLYPH_0;
         4'h1: glyph_o = GLYPH_1;
         4'h2: glyph_o = GLYPH_2;
         4'h3: glyph_o = GLYPH_3;
         4'h4: glyph_o = GLYPH_4;
         4'h5: glyph_o = GLYPH_5;
         4'h6: glyph_o = GLYPH_6;
         4'h7: glyph_o = GLYPH_7;
         4'h8: glyph_o = GLYPH_8;
         4'h9: glyph_o = GLYPH_9;
         4'hA: glyph_o = GLYPH_A;
         4'hB: glyph_o = GLYPH_B;
         4'hC: glyph_o = GLYPH_C;
         4'hD: glyph_o = GLYPH_D;
         4'hE: glyph_o = GLYPH_E;
         default: glyph_o = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for DIGITS common-anode digits.
// Each digit owns a slot of SCAN_DIV clocks; the first clock of every slot
// blanks all anodes to avoid ghosting while segments change.
//
// Ports:
//   clk          system clock, rising edge
//   clr_n        asynchronous active-low reset
//   disp_num     hex nibbles, digit i = disp_num[4i+3:4i]        (staged)
//   seg_raw      raw active-low pattern, digit i = seg_raw[8i+7:8i] (staged)
//   dp           decimal point per digit, 1 = lit                (staged)
//   mode         0 = hex decode, 1 = raw pattern                 (live)
//   lz_en        leading-zero blanking in hex mode               (live)
//   blink_mask   digits to blink                                 (live)
//   load_req     one-cycle request to capture the staged inputs
//   load_ack     one-cycle pulse when captured data becomes visible
//   load_pend    captured data is waiting for the next frame wrap
//   SEGMENT      registered active-low {dp,g,f,e,d,c,b,a}
//   AN           registered active-low digit enables
//   frame_done   one-cycle pulse after each frame wrap
//
// Handshake: load_req is a single-cycle strobe that is always accepted; the
// staging register holds the latest request, load_pend stays high until the
// frame-wrap tick copies it to the display register, and load_ack pulses once
// in the cycle after that copy.
//
// Build option: define SEVEN_SEG_BLINK_EN to include the blink counter and
// blink masking; without it blink_mask is ignored.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int DIGITS       = DEF_DIGITS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
)(
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic [4*DIGITS-1:0]   disp_num,
   input  logic [8*DIGITS-1:0]   seg_raw,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  mode,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  load_req,
   output logic                  load_ack,
   output logic                  load_pend,
   output logic [7:0]            SEGMENT,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_done
);

   localparam int IW = $clog2(DIGITS);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] stg_num_q, dsp_num_q, dsp_num_d;
   logic [8*DIGITS-1:0] stg_raw_q, dsp_raw_q, dsp_raw_d;
   logic [DIGITS-1:0]   stg_dp_q, dsp_dp_q, dsp_dp_d;
   logic                pend_q, pend_d;
   logic                ack_q, fd_q;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                tick, wrap, commit;
   logic [3:0]          nib;
   logic [7:0]          raw_byte;
   logic                dp_bit;
   logic                lz_hit;
   logic                zero_above;
   logic [6:0]          glyph;
   logic                blink_now;

   assign tick   = (presc_q == PRESC_LAST);
   assign wrap   = tick && (idx_q == IDX_LAST);
   assign commit = wrap && pend_q;

   // Timing and staging next state.
   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      dsp_num_d = commit ? stg_num_q : dsp_num_q;
      dsp_raw_d = commit ? stg_raw_q : dsp_raw_q;
      dsp_dp_d  = commit ? stg_dp_q  : dsp_dp_q;
      // A request on the wrap tick wins over the clear: it waits a full frame.
      pend_d = load_req ? 1'b1 : (wrap ? 1'b0 : pend_q);
   end

   // Select the digit that will be on display next cycle. The pattern is
   // built from next-state values so SEGMENT always matches idx_q.
   // zero_above walks from the top digit down, so at digit i it says whether
   // every nibble at index >= i is zero.
   always_comb begin
      nib        = 4'h0;
      raw_byte   = 8'h00;
      dp_bit     = 1'b0;
      lz_hit     = 1'b0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (dsp_num_d[4*i +: 4] == 4'h0);
         if (idx_d == IW'(i)) begin
            nib      = dsp_num_d[4*i +: 4];
            raw_byte = dsp_raw_d[8*i +: 8];
            dp_bit   = dsp_dp_d[i];
            lz_hit   = zero_above && (i != 0);
         end
      end
   end

   hex7seg_dec u_dec (
      .nib_i   (nib),
      .glyph_o (glyph)
   );

`ifdef SEVEN_SEG_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          mask_bit;

   // Phase flips after every BLINK_FRAMES frame wraps.
   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (wrap) begin
         if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      mask_bit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IW'(i)) mask_bit = blink_mask[i];
      end
   end

   assign blink_now = phase_d & mask_bit;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_blink_mask;
   assign unused_blink_mask = ^blink_mask;
   assign blink_now = 1'b0;
`endif

   always_comb begin
      seg_d = SEG_BLANK;
      if (blink_now) begin
         seg_d = SEG_BLANK;
      end else if (mode == MODE_RAW) begin
         seg_d = raw_byte;
      end else begin
         seg_d = {~dp_bit, (lz_en && lz_hit) ? GLYPH_OFF : glyph};
      end
      // The cycle after a tick is the guard cycle of the new slot.
      an_d = tick ? '1 : ~(AN_ONE << idx_d);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         presc_q   <= '0;
         idx_q     <= '0;
         stg_num_q <= '0;
         stg_raw_q <= '0;
         stg_dp_q  <= '0;
         dsp_num_q <= '0;
         dsp_raw_q <= '0;
         dsp_dp_q  <= '0;
         pend_q    <= 1'b0;
         ack_q     <= 1'b0;
         fd_q      <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= '1;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         if (load_req) begin
            stg_num_q <= disp_num;
            stg_raw_q <= seg_raw;
            stg_dp_q  <= dp;
         end
         dsp_num_q <= dsp_num_d;
         dsp_raw_q <= dsp_raw_d;
         dsp_dp_q  <= dsp_dp_d;
         pend_q    <= pend_d;
         ack_q     <= commit;
         fd_q      <= wrap;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign load_ack   = ack_q;
   assign load_pend  = pend_q;
   assign SEGMENT    = seg_q;
   assign AN         = an_q;
   assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits; legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 50000: clocks per digit slot; minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: full frames per blink half-period; minimum 1.
REQ-004 Ports, in order: clk, in, 1, system clock; all logic on rising edge.
REQ-005 clr_n, in, 1, reset; asynchronous assert, active-low.
REQ-006 disp_num, in, 4*DIGITS, hex nibbles; digit i = disp_num[4i+3:4i].
REQ-007 seg_raw, in, 8*DIGITS, raw active-low pattern per digit; digit i = seg_raw[8i+7:8i].
REQ-008 dp, in, DIGITS, decimal point per digit; 1 = lit.
REQ-009 mode, in, 1, display mode; 0 = hex decode, 1 = raw pattern.
REQ-010 lz_en, in, 1, enables leading-zero blanking in hex mode.
REQ-011 blink_mask, in, DIGITS, digits to blink.
REQ-012 load_req, in, 1, single-cycle request to capture disp_num/seg_raw/dp.
REQ-013 load_ack, out, 1, one-cycle pulse when captured data becomes visible.
REQ-014 load_pend, out, 1, high while captured data awaits its commit.
REQ-015 SEGMENT, out, 8, registered active-low segments {dp,g,f,e,d,c,b,a}.
REQ-016 AN, out, DIGITS, registered active-low digit enables.
REQ-017 frame_done, out, 1, one-cycle pulse at each frame wrap.

Function
REQ-018 Prescaler counts 0..SCAN_DIV-1 and wraps; the wrap cycle is a slot tick.
REQ-019 Digit index advances 0..DIGITS-1 on each tick and wraps to 0.
REQ-020 frame_done asserts in the cycle after the tick that wraps the index from DIGITS-1 to 0.
REQ-021 load_req captures inputs into a staging register and sets load_pend; a later load_req before commit overwrites the staging register.
REQ-022 The commit copies staging to the display register on the frame-wrap tick; that tick clears load_pend and pulses load_ack in the next cycle.
REQ-023 load_req coincident with the frame-wrap tick is captured and commits at the following frame wrap.
REQ-024 Ghost guard: AN is all-ones for the first cycle of each slot, then drives only the active digit low for the rest of the slot.
REQ-025 SEGMENT/AN update one cycle after the tick; SEGMENT holds the pattern for the current index.
REQ-026 Hex mode: bits [6:0] are the standard active-low 0-F glyphs; bit 7 = ~dp[i].
REQ-027 Raw mode: SEGMENT = seg_raw digit i; dp is ignored.
REQ-028 Leading-zero blanking applies only when lz_en=1 and mode=0.
REQ-029 Under blanking, digit i shows 7'h7F when all nibbles at index >= i are zero; digit 0 is never blanked; dp stays visible.
REQ-030 Blink phase toggles every BLINK_FRAMES frame wraps.
REQ-031 While blink phase=1, digits with blink_mask[i]=1 output SEGMENT=8'hFF; their AN timing is unchanged.
REQ-032 mode, lz_en and blink_mask are sampled live, not staged.

Reset
REQ-033 While clr_n=0: AN all-ones, SEGMENT=8'hFF, frame_done=0, load_ack=0, load_pend=0.
REQ-034 While clr_n=0: prescaler, index, blink phase, blink counter, staging and display registers are all 0.
REQ-035 A reset mid-frame discards any pending load; after release the first slot starts at index 0 with prescaler 0.

Configuration
REQ-036 With SEVEN_SEG_BLINK_EN defined, the blink counter and masking exist as specified.
REQ-037 Without SEVEN_SEG_BLINK_EN, blink_mask is ignored, no blink logic exists, and all other behaviour is identical.

Structure
REQ-038 Package seven_seg_pkg holds the 16 glyph constants, SEG_BLANK=8'hFF, and the DIGITS/SCAN_DIV defaults.
REQ-039 Sub-module hex7seg_dec is the combinational nibble-to-7-bit decoder, instantiated once on the indexed nibble.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-040 Reset release, then 16 clocks -> AN sequence 1110,1101,1011,0111, each preceded by one 1111 guard cycle; frame_done pulses once.
REQ-041 load_req with disp_num=16'h12AF, mode=0 -> load_pend high until frame wrap, then one load_ack pulse; slots show F, A, 2, 1.
REQ-042 disp_num=16'h0050, lz_en=1 -> digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0.
REQ-043 Two load_req pulses (16'h1111, then 16'h2222) in one frame -> single load_ack; display shows 2222.
REQ-044 Blink build, blink_mask=4'b0001 -> digit 0 SEGMENT=8'hFF on alternate 2-frame periods; other digits unaffected.
REQ-045 clr_n pulsed low mid-slot with a load pending -> outputs reach reset values asynchronously, load_pend=0, old display data not restored.
